// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0)
// and the data stage (port 1), sequencing each access through a fixed read latency.
module mem_port_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] mem_rdata,
  output logic          sel,
  output logic          gnt0,
  output logic          gnt1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_n;
  logic [2:0]    cnt, cnt_n;
  logic          last, last_n;
  logic          wr, wr_n;
  logic          sel_n, gnt0_n, gnt1_n, mem_en_n, mem_we_n, done0_n, done1_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n, rdata_n;
  logic          win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      wr        <= 1'b0;
      sel       <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last      <= last_n;
      wr        <= wr_n;
      sel       <= sel_n;
      gnt0      <= gnt0_n;
      gnt1      <= gnt1_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      done0     <= done0_n;
      done1     <= done1_n;
      rdata     <= rdata_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_n      = last;
    wr_n        = wr;
    sel_n       = sel;
    gnt0_n      = gnt0;
    gnt1_n      = gnt1;
    mem_en_n    = mem_en;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    done0_n     = done0;
    done1_n     = done1;
    rdata_n     = rdata;
    win         = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not win last time gets the grant
          win         = (req0 && req1) ? ~last : req1;
          sel_n       = win;
          gnt0_n      = ~win;
          gnt1_n      = win;
          last_n      = win;
          mem_addr_n  = win ? addr1 : addr0;
          mem_we_n    = we1 & win;
          wr_n        = we1 & win;
          if (win) mem_wdata_n = wdata1;
          mem_en_n    = 1'b1;
          cnt_n       = 3'(LAT);
          state_n     = BUSY;
        end
      end
      BUSY: begin
        mem_en_n = 1'b0;
        mem_we_n = 1'b0;
        cnt_n    = cnt - 3'd1;
        if (cnt == 3'd1) begin
          if (!wr) rdata_n = mem_rdata;
          done0_n = ~sel;
          done1_n = sel;
          state_n = DONE;
        end
      end
      DONE: begin
        done0_n = 1'b0;
        done1_n = 1'b0;
        gnt0_n  = 1'b0;
        gnt1_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a runs LAT=1, instance b runs LAT=3,
// both sharing the requester-side inputs.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        req0, req1, we1;
  logic [31:0] addr0, addr1, wdata1, mem_rdata;

  logic        a_sel, a_gnt0, a_gnt1, a_mem_en, a_mem_we, a_done0, a_done1;
  logic [31:0] a_mem_addr, a_mem_wdata, a_rdata;
  logic        b_sel, b_gnt0, b_gnt1, b_mem_en, b_mem_we, b_done0, b_done1;
  logic [31:0] b_mem_addr, b_mem_wdata, b_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .req1(req1), .we1(we1),
    .addr1(addr1), .wdata1(wdata1), .mem_rdata(mem_rdata), .sel(a_sel),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .done0(a_done0),
    .done1(a_done1), .rdata(a_rdata)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(3)) dut_b (
    .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .req1(req1), .we1(we1),
    .addr1(addr1), .wdata1(wdata1), .mem_rdata(mem_rdata), .sel(b_sel),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .done0(b_done0),
    .done1(b_done1), .rdata(b_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 0; req1 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata1 = '0; mem_rdata = '0;
    #2;
    checks++; if ({a_sel, a_gnt0, a_gnt1, a_mem_en, a_mem_we, a_done0, a_done1} !== 7'b0) begin
      errors++; $display("FAIL reset_a_ctrl: got %b expected 0000000",
        {a_sel, a_gnt0, a_gnt1, a_mem_en, a_mem_we, a_done0, a_done1}); end
    checks++; if ({a_mem_addr, a_mem_wdata, a_rdata} !== 96'h0) begin
      errors++; $display("FAIL reset_a_data: got %h expected 0", {a_mem_addr, a_mem_wdata, a_rdata}); end
    checks++; if ({b_sel, b_gnt0, b_gnt1, b_mem_en, b_mem_we, b_done0, b_done1} !== 7'b0) begin
      errors++; $display("FAIL reset_b_ctrl: got %b expected 0000000",
        {b_sel, b_gnt0, b_gnt1, b_mem_en, b_mem_we, b_done0, b_done1}); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({a_gnt0, a_gnt1, a_mem_en} !== 3'b000) begin
      errors++; $display("FAIL idle_no_req: got %b expected 000", {a_gnt0, a_gnt1, a_mem_en}); end
  endtask

  task automatic test_lat1_read();
    req0 = 1; addr0 = 32'h0040_0000; mem_rdata = 32'h2402_000A;
    tick();  // grant edge
    checks++; if ({a_gnt0, a_gnt1, a_sel, a_mem_en, a_mem_we} !== 5'b10010) begin
      errors++; $display("FAIL lat1_grant: got %b expected 10010", {a_gnt0, a_gnt1, a_sel, a_mem_en, a_mem_we}); end
    checks++; if (a_mem_addr !== 32'h0040_0000) begin
      errors++; $display("FAIL lat1_addr: got %h expected 00400000", a_mem_addr); end
    tick();
    checks++; if ({a_done0, a_done1, a_mem_en, a_gnt0} !== 4'b1001) begin
      errors++; $display("FAIL lat1_done: got %b expected 1001", {a_done0, a_done1, a_mem_en, a_gnt0}); end
    checks++; if (a_rdata !== 32'h2402_000A) begin
      errors++; $display("FAIL lat1_rdata: got %h expected 2402000a", a_rdata); end
    req0 = 0;
    tick();
    checks++; if ({a_done0, a_gnt0, a_sel} !== 3'b000) begin
      errors++; $display("FAIL lat1_release: got %b expected 000", {a_done0, a_gnt0, a_sel}); end
  endtask

  task automatic test_write();
    req1 = 1; we1 = 1; addr1 = 32'h1001_0000; wdata1 = 32'hDEAD_BEEF; mem_rdata = 32'h5555_5555;
    tick();
    checks++; if ({a_gnt1, a_sel, a_mem_en, a_mem_we} !== 4'b1111) begin
      errors++; $display("FAIL wr_strobe: got %b expected 1111", {a_gnt1, a_sel, a_mem_en, a_mem_we}); end
    checks++; if ({a_mem_addr, a_mem_wdata} !== {32'h1001_0000, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL wr_addr_data: got %h expected 10010000deadbeef", {a_mem_addr, a_mem_wdata}); end
    tick();
    checks++; if ({a_done1, a_done0, a_mem_en, a_mem_we} !== 4'b1000) begin
      errors++; $display("FAIL wr_done: got %b expected 1000", {a_done1, a_done0, a_mem_en, a_mem_we}); end
    checks++; if (a_rdata !== 32'h2402_000A) begin
      errors++; $display("FAIL wr_rdata_hold: got %h expected 2402000a", a_rdata); end
    req1 = 0; we1 = 0;
    tick();
    checks++; if ({a_done1, a_gnt1} !== 2'b00) begin
      errors++; $display("FAIL wr_release: got %b expected 00", {a_done1, a_gnt1}); end
  endtask

  task automatic test_lat3_read();
    do_reset();
    req1 = 1; we1 = 0; addr1 = 32'h1001_0004; mem_rdata = 32'hAAAA_0001;
    tick();  // grant edge E0
    checks++; if ({b_gnt1, b_sel, b_mem_en, b_mem_we} !== 4'b1110) begin
      errors++; $display("FAIL lat3_grant: got %b expected 1110", {b_gnt1, b_sel, b_mem_en, b_mem_we}); end
    checks++; if (b_mem_addr !== 32'h1001_0004) begin
      errors++; $display("FAIL lat3_addr: got %h expected 10010004", b_mem_addr); end
    tick();  // E1
    checks++; if ({b_mem_en, b_done1} !== 2'b00) begin
      errors++; $display("FAIL lat3_e1: got %b expected 00", {b_mem_en, b_done1}); end
    tick();  // E2
    checks++; if (b_done1 !== 1'b0) begin
      errors++; $display("FAIL lat3_e2_early_done: got %b expected 0", b_done1); end
    mem_rdata = 32'h1234_5678;
    tick();  // E3
    checks++; if ({b_done1, b_done0, b_gnt1} !== 3'b101) begin
      errors++; $display("FAIL lat3_done: got %b expected 101", {b_done1, b_done0, b_gnt1}); end
    checks++; if (b_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL lat3_rdata: got %h expected 12345678", b_rdata); end
    req1 = 0;
    tick();  // E4
    checks++; if ({b_done1, b_gnt1, b_sel} !== 3'b001) begin
      errors++; $display("FAIL lat3_release: got %b expected 001", {b_done1, b_gnt1, b_sel}); end
    tick();
    checks++; if ({b_gnt0, b_gnt1, b_mem_en} !== 3'b000) begin
      errors++; $display("FAIL lat3_idle: got %b expected 000", {b_gnt0, b_gnt1, b_mem_en}); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    req0 = 1; req1 = 1; we1 = 0; addr0 = 32'h0000_0100; addr1 = 32'h0000_0200;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++; if ((a_gnt0 & a_gnt1) !== 1'b0) begin
        errors++; $display("FAIL rr_overlap: got %b expected 0 at cycle %0d", a_gnt0 & a_gnt1, k); end
      if (k % 3 == 0) begin
        exp = ((k / 3) % 2 == 0) ? 3'b100 : 3'b011;  // {gnt0,gnt1,sel}
        checks++; if ({a_gnt0, a_gnt1, a_sel} !== exp) begin
          errors++; $display("FAIL rr_grant: got %b expected %b at access %0d", {a_gnt0, a_gnt1, a_sel}, exp, k / 3); end
      end
      if (k % 3 == 1) begin
        exp = ((k / 3) % 2 == 0) ? 3'b100 : 3'b010;  // {done0,done1,0}
        checks++; if ({a_done0, a_done1, 1'b0} !== exp) begin
          errors++; $display("FAIL rr_done: got %b expected %b at access %0d", {a_done0, a_done1, 1'b0}, exp, k / 3); end
      end
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req0 = 1; addr0 = 32'h0040_0100;
    tick();  // E0
    checks++; if ({b_gnt0, b_mem_en} !== 2'b11) begin
      errors++; $display("FAIL midrst_grant: got %b expected 11", {b_gnt0, b_mem_en}); end
    tick();  // E1, counter now 2
    rst = 1'b1;
    #1;
    checks++; if ({b_sel, b_gnt0, b_gnt1, b_mem_en, b_mem_we, b_done0, b_done1} !== 7'b0 ||
                  b_mem_addr !== 32'h0) begin
      errors++; $display("FAIL midrst_async: got %b/%h expected 0000000/00000000",
        {b_sel, b_gnt0, b_gnt1, b_mem_en, b_mem_we, b_done0, b_done1}, b_mem_addr); end
    addr0 = 32'h0040_0200;
    tick(); tick();
    checks++; if ({b_done0, b_gnt0} !== 2'b00) begin
      errors++; $display("FAIL midrst_no_done: got %b expected 00", {b_done0, b_gnt0}); end
    rst = 1'b0;
    tick();
    checks++; if ({b_gnt0, b_sel, b_mem_en} !== 3'b101 || b_mem_addr !== 32'h0040_0200) begin
      errors++; $display("FAIL midrst_regrant: got %b/%h expected 101/00400200", {b_gnt0, b_sel, b_mem_en}, b_mem_addr); end
    tick(); tick(); tick();
    checks++; if (b_done0 !== 1'b1) begin
      errors++; $display("FAIL midrst_regrant_done: got %b expected 1", b_done0); end
    req0 = 0;
    tick();
  endtask

  task automatic test_addr_change();
    do_reset();
    req1 = 1; we1 = 0; addr1 = 32'h1001_0020; mem_rdata = 32'hCAFE_0020;
    tick();  // E0
    checks++; if (b_mem_addr !== 32'h1001_0020) begin
      errors++; $display("FAIL ach_first_addr: got %h expected 10010020", b_mem_addr); end
    addr1 = 32'h1001_0040;
    tick(); tick();
    checks++; if (b_mem_addr !== 32'h1001_0020) begin
      errors++; $display("FAIL ach_addr_held: got %h expected 10010020", b_mem_addr); end
    tick();  // E3
    checks++; if (b_done1 !== 1'b1) begin
      errors++; $display("FAIL ach_done: got %b expected 1", b_done1); end
    tick();  // E4: back to idle, request still high
    checks++; if ({b_gnt1, b_mem_en} !== 2'b00) begin
      errors++; $display("FAIL ach_idle_gap: got %b expected 00", {b_gnt1, b_mem_en}); end
    tick();  // E5: second grant
    checks++; if ({b_gnt1, b_sel, b_mem_en} !== 3'b111 || b_mem_addr !== 32'h1001_0040) begin
      errors++; $display("FAIL ach_second: got %b/%h expected 111/10010040", {b_gnt1, b_sel, b_mem_en}, b_mem_addr); end
    req1 = 0;
  endtask

  initial begin
    test_reset();
    test_lat1_read();
    test_write();
    test_lat3_read();
    test_round_robin();
    test_reset_mid_busy();
    test_addr_change();
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
